prog_loader: RTL
================

# prog_loader

Host-side program memory writer for the pipelined RISC-V core, the write-side counterpart of the fetch stage's instruction read path. It receives instruction bytes from the TinyTapeout pins through a four-phase strobe/ack handshake and assembles them little-endian into 32-bit words. It writes each word into program memory at an auto-incrementing address. While loading, it holds the CPU in reset so fetch never sees a half-written program.

## Interface
- `ADDR_W`, default 5: program memory word-address width; depth is 2^ADDR_W words.
- `SYNC_STAGES`, default 2: flip-flop stages on each asynchronous pin input; minimum 2.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `load_en` in 1: asynchronous pin level; high requests load mode.
- `byte_strobe` in 1: asynchronous host strobe; `byte_in` must be stable while it is high.
- `byte_in` in 8: instruction byte, sampled on the detected strobe rising edge.
- `mem_we` out 1: one-cycle program memory write enable.
- `mem_addr` out ADDR_W: word address for the write.
- `mem_wdata` out 32: assembled instruction word.
- `cpu_hold` out 1: high while loading; keeps the PC and pipeline in reset.
- `byte_ack` out 1: handshake acknowledge to the host.
- `overflow` out 1: sticky; a word arrived after memory was full.
- `frame_err` out 1: sticky; load ended with a partial word.

## Operation
- `load_en` and `byte_strobe` each pass through SYNC_STAGES flops, giving `load_s` and `strobe_s`. A strobe edge is `strobe_s` high while its previous value was low. `byte_in` is not synchronized; the handshake guarantees it is stable.
- **IDLE**: `cpu_hold`=0 and strobe edges are ignored. When `load_s` is high, go to LOAD and clear `mem_addr`, `byte_idx`, `overflow`, `frame_err` and `full`.
- **LOAD**: `cpu_hold`=1.
  - On a strobe edge with `load_s` high, write `byte_in` into `mem_wdata[8*byte_idx +: 8]` and set `byte_ack`.
  - `byte_idx` is 2 bits and counts 0..3.
  - On capture of the byte at `byte_idx`=3, go to WRITE.
  - When `load_s` is low, go to IDLE. If `byte_idx`≠0, set `frame_err` and discard the partial word.
- **WRITE**, one cycle:
  - If `full`=0, assert `mem_we` with the current `mem_addr` and `mem_wdata`.
  - Then increment `mem_addr`. A carry out of the top bit sets `full`, and `mem_addr` wraps to 0.
  - If `full`=1, suppress `mem_we` and set `overflow`.
  - Clear `byte_idx` and return to LOAD. A word completed just before `load_en` falls is always written.
- `byte_ack` clears on the first cycle in which `strobe_s` is low. It is never set in IDLE.
- Byte order: the first byte received is bits [7:0] and the fourth is bits [31:24].

## Timing
- **Reset values**: all outputs are 0, the state is IDLE, and the synchronizer flops and the `strobe_s` previous-value flop are 0.
- **Reset mid-load**: `mem_we` drops immediately and no partial word is written.
- **Pin to internal**: a pin change appears on `load_s`/`strobe_s` SYNC_STAGES cycles later.
- **Strobe to ack**: the capture happens in the cycle the edge is detected, and `byte_ack` is high from the next cycle. Total: SYNC_STAGES+1 cycles after the strobe pin rises.
- **Fourth byte to write**: `mem_we` is high exactly one cycle after the fourth capture, and `mem_addr` increments in the cycle after that.
- **Write while lowering strobe**: back-to-back bytes are legal. A strobe edge cannot occur during WRITE because the host must first see `byte_ack` low.
- **`cpu_hold` rise**: `cpu_hold` rises the cycle after `load_s` rises.
- **`cpu_hold` fall**: `cpu_hold` falls the cycle after LOAD sees `load_s` low. If that happens in WRITE, the fall is deferred one cycle.
- **Simultaneous strobe edge and `load_s` low**: no capture happens; `load_s` low wins.

## Test plan
- **Reset**: assert `rst` for 3 cycles, then release. All outputs must be 0; drive strobes with `load_en`=0 and `byte_ack` must stay 0.
- **Single word load**: raise `load_en`, then send bytes 0x13,0x05,0xA0,0x00. `mem_we` must pulse once with `mem_addr`=0 and `mem_wdata`=0x00A00513. `cpu_hold` must fall SYNC_STAGES+1 cycles after `load_en` drops.
- **Multiple words and ack timing**: load 3 words. Writes must land at addresses 0,1,2. Each `byte_ack` must rise exactly SYNC_STAGES+1 cycles after the `byte_strobe` pin rises.
- **Partial word**: send 2 bytes, then drop `load_en`. There must be no `mem_we` and `frame_err`=1. Re-entering load must clear `frame_err` and restart at `mem_addr`=0.
- **Overflow**: load 33 words with ADDR_W=5. There must be exactly 32 `mem_we` pulses, and the last written address is 31. After the 33rd word `overflow`=1, and address 0 is not overwritten.
- **Async reset mid-word**: assert `rst` after the third byte. There must be no write, and all outputs must be 0 within the same cycle.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: host-side program memory writer.
// Receives instruction bytes over a four-phase strobe/ack handshake, assembles them
// little-endian into 32-bit words and writes each word to program memory at an
// auto-incrementing word address. The CPU is held in reset while loading.
//
// Ports:
//   i_clk, i_rst        system clock, asynchronous active-high reset
//   i_load_en           async pin, high requests load mode
//   i_byte_strobe       async host strobe, i_byte_in stable while high
//   i_byte_in[7:0]      instruction byte
//   o_mem_we            one-cycle program memory write enable
//   o_mem_addr          word address of the write
//   o_mem_wdata[31:0]   assembled instruction word
//   o_cpu_hold          high while loading
//   o_byte_ack          handshake acknowledge
//   o_overflow          sticky, a word arrived after memory was full
//   o_frame_err         sticky, load ended with a partial word
module prog_loader #(
    parameter int unsigned ADDR_W      = 5,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load_en,
    input  logic              i_byte_strobe,
    input  logic [7:0]        i_byte_in,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic              o_cpu_hold,
    output logic              o_byte_ack,
    output logic              o_overflow,
    output logic              o_frame_err
);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StWrite
    } state_e;

    state_e                 r_state,  w_state_d;
    logic [SYNC_STAGES-1:0] r_load_sync;
    logic [SYNC_STAGES-1:0] r_strobe_sync;
    logic                   r_strobe_prev;
    logic [ADDR_W-1:0]      r_addr,   w_addr_d;
    logic [1:0]             r_idx,    w_idx_d;
    logic [31:0]            r_wdata,  w_wdata_d;
    logic                   r_ack,    w_ack_d;
    logic                   r_full,   w_full_d;
    logic                   r_ovf,    w_ovf_d;
    logic                   r_ferr,   w_ferr_d;

    logic                   w_load_s;
    logic                   w_strobe_s;
    logic                   w_strobe_edge;
    logic [ADDR_W:0]        w_addr_inc;

    assign w_load_s      = r_load_sync[SYNC_STAGES-1];
    assign w_strobe_s    = r_strobe_sync[SYNC_STAGES-1];
    assign w_strobe_edge = w_strobe_s & ~r_strobe_prev;
    // Extra top bit carries out of the address; it marks memory as full.
    assign w_addr_inc    = {1'b0, r_addr} + {{ADDR_W{1'b0}}, 1'b1};

    // Pin synchronizers and strobe edge history.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_load_sync   <= '0;
            r_strobe_sync <= '0;
            r_strobe_prev <= 1'b0;
        end else begin
            r_load_sync   <= {r_load_sync[SYNC_STAGES-2:0], i_load_en};
            r_strobe_sync <= {r_strobe_sync[SYNC_STAGES-2:0], i_byte_strobe};
            r_strobe_prev <= w_strobe_s;
        end
    end

    // State and datapath registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_addr  <= '0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_ack   <= 1'b0;
            r_full  <= 1'b0;
            r_ovf   <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_addr  <= w_addr_d;
            r_idx   <= w_idx_d;
            r_wdata <= w_wdata_d;
            r_ack   <= w_ack_d;
            r_full  <= w_full_d;
            r_ovf   <= w_ovf_d;
            r_ferr  <= w_ferr_d;
        end
    end

    // Next-state logic and the combinational write enable.
    always_comb begin
        w_state_d = r_state;
        w_addr_d  = r_addr;
        w_idx_d   = r_idx;
        w_wdata_d = r_wdata;
        // Ack drops on the first cycle the synchronized strobe is low.
        w_ack_d   = r_ack & w_strobe_s;
        w_full_d  = r_full;
        w_ovf_d   = r_ovf;
        w_ferr_d  = r_ferr;
        o_mem_we  = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (w_load_s) begin
                    w_state_d = StLoad;
                    w_addr_d  = '0;
                    w_idx_d   = '0;
                    w_full_d  = 1'b0;
                    w_ovf_d   = 1'b0;
                    w_ferr_d  = 1'b0;
                end
            end
            StLoad: begin
                // Dropping load wins over a coincident strobe edge.
                if (!w_load_s) begin
                    w_state_d = StIdle;
                    if (r_idx != 2'd0) begin
                        w_ferr_d = 1'b1;
                    end
                    w_idx_d = '0;
                end else if (w_strobe_edge) begin
                    w_wdata_d[{r_idx, 3'b000} +: 8] = i_byte_in;
                    w_ack_d = 1'b1;
                    w_idx_d = r_idx + 2'd1;
                    if (r_idx == 2'd3) begin
                        w_state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                o_mem_we = ~r_full;
                if (r_full) begin
                    w_ovf_d = 1'b1;
                end
                w_addr_d  = w_addr_inc[ADDR_W-1:0];
                w_full_d  = r_full | w_addr_inc[ADDR_W];
                w_idx_d   = '0;
                w_state_d = StLoad;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_wdata;
    assign o_cpu_hold  = (r_state != StIdle);
    assign o_byte_ack  = r_ack;
    assign o_overflow  = r_ovf;
    assign o_frame_err = r_ferr;

endmodule
